// File: rtl/input_port_router.sv
// Buffered input port of an XY-routed mesh router: queues incoming flits, computes the
// route from each head flit, reserves a switch path, forwards the packet, then releases it.
module input_port_router #(
    parameter int N             = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int X_POS         = 0,
    parameter int Y_POS         = 0,
    parameter int REQUEST_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic                     routeReserveStatus,
    output logic                     routeRelieve,
    output logic                     drop_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int IDW = $clog2(N * N);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ZERO_C  = {(AW + 1){1'b0}};

    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam logic [REQUEST_WIDTH-1:0] PORT_NORTH = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] PORT_SOUTH = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] PORT_WEST  = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] PORT_EAST  = REQUEST_WIDTH'(3);
    localparam logic [REQUEST_WIDTH-1:0] PORT_LOCAL = REQUEST_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_ACTIVE  = 2'b10,
        S_RELIEVE = 2'b11
    } state_t;

    // Dimension-ordered routing: resolve X first, then Y.
    function automatic logic [REQUEST_WIDTH-1:0] xy_route(input logic [IDW-1:0] id);
        int dest_x;
        int dest_y;
        dest_x = int'(id) % N;
        dest_y = int'(id) / N;
        if (dest_x > X_POS)      xy_route = PORT_EAST;
        else if (dest_x < X_POS) xy_route = PORT_WEST;
        else if (dest_y > Y_POS) xy_route = PORT_NORTH;
        else if (dest_y < Y_POS) xy_route = PORT_SOUTH;
        else                     xy_route = PORT_LOCAL;
    endfunction

    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_count;
    state_t                   r_state;
    state_t                   w_next_state;
    logic [REQUEST_WIDTH-1:0] r_route;
    logic                     r_drop_err;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_latch;
    logic                     w_drop;
    logic [DATA_WIDTH-1:0]    w_head;
    logic [1:0]               w_head_type;
    logic                     w_is_start;
    logic                     w_is_end;

    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == ZERO_C);
    assign in_ready    = ~rst & ~w_full;
    assign w_push      = in_valid & in_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_type = w_head[DATA_WIDTH-1 -: 2];
    assign w_is_start  = (w_head_type == TYPE_HEAD) | (w_head_type == TYPE_SINGLE);
    assign w_is_end    = (w_head_type == TYPE_TAIL) | (w_head_type == TYPE_SINGLE);

    assign out_data            = w_head;
    assign routeReserveRequest = r_route;
    assign drop_err            = r_drop_err;

    // Flit buffer: circular pointers plus an occupancy count; a push is never taken while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= ZERO_C;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; the grant input only matters while requesting.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && w_is_start) w_next_state = S_REQ;
                else                        w_next_state = S_IDLE;
            end
            S_REQ: begin
                if (routeReserveStatus) w_next_state = S_ACTIVE;
                else                    w_next_state = S_REQ;
            end
            S_ACTIVE: begin
                if (w_pop && w_is_end) w_next_state = S_RELIEVE;
                else                   w_next_state = S_ACTIVE;
            end
            S_RELIEVE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: stray body/tail flits are dropped while idle, heads only latch a route.
    always_comb begin
        out_valid                = 1'b0;
        routeReserveRequestValid = 1'b0;
        routeRelieve             = 1'b0;
        w_pop                    = 1'b0;
        w_latch                  = 1'b0;
        w_drop                   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_latch = ~w_empty & w_is_start;
                w_drop  = ~w_empty & ~w_is_start;
                w_pop   = ~w_empty & ~w_is_start;
            end
            S_REQ: begin
                routeReserveRequestValid = 1'b1;
            end
            S_ACTIVE: begin
                out_valid = ~w_empty;
                w_pop     = ~w_empty & out_ready;
            end
            S_RELIEVE: begin
                routeRelieve = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Latched route and the registered drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_route    <= {REQUEST_WIDTH{1'b0}};
            r_drop_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_route <= xy_route(w_head[IDW-1:0]);
            end else begin
                r_route <= r_route;
            end
            r_drop_err <= w_drop;
        end
    end

endmodule

// File: tb/tb_input_port_router.sv
// Self-checking bench for input_port_router on a 4x4 mesh at node (1,1): directed scenarios
// followed by random packets checked against a queue scoreboard and an arithmetic route model.
module tb_input_port_router;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       rrv;
    logic [2:0] rr;
    logic       grant;
    logic       relieve;
    logic       drop_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] pkt[$];

    input_port_router #(
        .N(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .X_POS(1), .Y_POS(1), .REQUEST_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .routeReserveRequestValid(rrv), .routeReserveRequest(rr),
        .routeReserveStatus(grant), .routeRelieve(relieve), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference route for node (1,1) of a 4x4 mesh.
    function automatic logic [2:0] ref_route(input int id);
        int dx;
        int dy;
        dx = id % 4;
        dy = id / 4;
        if (dx > 1)      return 3'd3;
        else if (dx < 1) return 3'd2;
        else if (dy > 1) return 3'd0;
        else if (dy < 1) return 3'd1;
        else             return 3'd4;
    endfunction

    // Push pkt, expect one request for exp_route, grant it, drain and expect one release.
    task automatic do_packet(input string name, input logic [2:0] exp_route, input bit rand_ready);
        int n;
        int got;
        int w;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            check({name, "_in_ready"}, 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        w = 0;
        while (!rrv && w < 10) begin
            tick();
            w++;
        end
        check({name, "_req_valid"}, 32'(rrv), 32'd1);
        check({name, "_req_port"}, 32'(rr), 32'(exp_route));
        grant = 1'b1;
        tick();
        grant = 1'b0;
        got = 0;
        w = 0;
        while (got < n && w < 40) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check({name, "_out_valid"}, 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                check({name, "_out_data"}, 32'(out_data), 32'(pkt[got]));
                got++;
            end
            tick();
            w++;
        end
        out_ready = 1'b1;
        check({name, "_all_flits"}, 32'(got), 32'(n));
        check({name, "_relieve"}, 32'(relieve), 32'd1);
        tick();
        check({name, "_relieve_once"}, 32'(relieve), 32'd0);
        check({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int id;
        int len;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        grant     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(rrv), 32'd0);
        check("rst_req_port", 32'(rr), 32'd0);
        check("rst_relieve", 32'(relieve), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // A grant while idle must be ignored
        grant = 1'b1;
        tick();
        grant = 1'b0;
        tick();
        check("stray_grant_out_valid", 32'(out_valid), 32'd0);
        check("stray_grant_req", 32'(rrv), 32'd0);

        // Single flit 0xC7: exact latency (cycle t = write cycle)
        in_valid = 1'b1;
        in_data  = 8'hC7;
        tick();                                 // t+1
        in_valid = 1'b0;
        check("c7_t1_req", 32'(rrv), 32'd0);
        tick();                                 // t+2
        check("c7_t2_req", 32'(rrv), 32'd1);
        check("c7_t2_port", 32'(rr), 32'd3);
        tick();                                 // t+3
        check("c7_t3_req_held", 32'(rrv), 32'd1);
        tick();                                 // t+4
        grant = 1'b1;
        check("c7_t4_out_valid", 32'(out_valid), 32'd0);
        tick();                                 // t+5
        grant = 1'b0;
        check("c7_t5_out_valid", 32'(out_valid), 32'd1);
        check("c7_t5_out_data", 32'(out_data), 32'hC7);
        check("c7_t5_req", 32'(rrv), 32'd0);
        tick();                                 // t+6
        check("c7_t6_relieve", 32'(relieve), 32'd1);
        check("c7_t6_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("c7_t7_relieve", 32'(relieve), 32'd0);

        // Multi-flit packets and the remaining port codes
        pkt = '{8'h4D, 8'h05, 8'h80};
        do_packet("north_pkt", 3'd0, 1'b0);
        pkt = '{8'h45, 8'h80};
        do_packet("local_pkt", 3'd4, 1'b0);
        pkt = '{8'h40, 8'h80};
        do_packet("west_pkt", 3'd2, 1'b0);

        // Stray body flit is dropped with a single drop_err pulse
        in_valid = 1'b1;
        in_data  = 8'h12;
        tick();
        in_valid = 1'b0;
        check("stray_c1_drop", 32'(drop_err), 32'd0);
        tick();
        check("stray_c2_drop", 32'(drop_err), 32'd1);
        check("stray_c2_req", 32'(rrv), 32'd0);
        tick();
        check("stray_c3_drop", 32'(drop_err), 32'd0);
        check("stray_c3_req", 32'(rrv), 32'd0);

        // Full FIFO with grant withheld
        pkt = '{8'h4D, 8'h01, 8'h02, 8'h83};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            tick();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_req", 32'(rrv), 32'd1);
        in_data = 8'h99;
        grant   = 1'b1;
        tick();
        in_valid = 1'b0;
        grant    = 1'b0;
        check("full_still_full", 32'(in_ready), 32'd0);
        check("full_first_out", 32'(out_data), 32'h4D);
        tick();
        check("full_after_pop_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check("full_drain_valid", 32'(out_valid), 32'd1);
            check("full_drain_data", 32'(out_data), 32'(pkt[i]));
            tick();
        end
        check("full_relieve", 32'(relieve), 32'd1);
        tick();
        check("full_5th_not_taken", 32'(out_valid), 32'd0);
        check("full_5th_no_req", 32'(rrv), 32'd0);

        // Reset in ACTIVE with two flits buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h4D;
        tick();
        in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        check("ract_req", 32'(rrv), 32'd1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        check("ract_active", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("ract_out_valid", 32'(out_valid), 32'd0);
        check("ract_relieve", 32'(relieve), 32'd0);
        check("ract_in_ready", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("ract_post_relieve", 32'(relieve), 32'd0);
        check("ract_post_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("ract_empty_no_req", 32'(rrv), 32'd0);
        check("ract_empty_no_out", 32'(out_valid), 32'd0);

        // Random packets against the scoreboard
        for (int p = 0; p < 12; p++) begin
            id  = int'($urandom_range(0, 15));
            len = int'($urandom_range(1, 4));
            pkt.delete();
            if (len == 1) begin
                pkt.push_back(8'hC0 | 8'(id));
            end else begin
                pkt.push_back({2'b01, 2'($urandom_range(0, 3)), 4'(id)});
                for (int b = 0; b < len - 2; b++) pkt.push_back({2'b00, 6'($urandom)});
                pkt.push_back({2'b10, 6'($urandom)});
            end
            do_packet("rand_pkt", ref_route(id), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
